// File: rtl/serial_subtractor_nb.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_nb
//  Description : Bit-serial n-bit subtractor (diff = a - b - bin), one bit per
//                clock LSB first, built around a single full-adder cell with a
//                start/busy/done handshake and registered results.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_nb #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  // Counter is one bit wider than log2(n) so it never wraps before n-1.
  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] c_last = CW'(n - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [n-1:0]  r_a;
  logic [n-1:0]  r_b;
  logic [n-1:0]  r_part;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic          w_nb;
  logic          w_s;
  logic          w_cout;
  logic          w_last;
  logic [n:0]    w_cat;
  logic [n-1:0]  w_part_next;

  // Single full-adder cell: a + ~b + carry, operating on the current LSBs.
  assign w_nb   = ~r_b[0];
  assign w_s    = r_a[0] ^ w_nb ^ r_carry;
  assign w_cout = (r_a[0] & w_nb) | (r_a[0] & r_carry) | (w_nb & r_carry);
  assign w_last = (r_cnt == c_last);

  // New sum bit enters at the top so the first (LSB) bit lands at position 0
  // after n shifts; concatenation keeps the n=1 case well formed.
  assign w_cat       = {w_s, r_part};
  assign w_part_next = w_cat[n:1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_cnt   <= '0;
            r_part  <= '0;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_part  <= w_part_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + c_one;
          if (w_last) begin
            // r_carry is c_{n-1} here and w_cout is c_n.
            diff <= w_part_next;
            bout <= ~w_cout;
            ovf  <= r_carry ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_nb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_nb
//  Description : Scoreboard testbench for serial_subtractor_nb (n=16 and n=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_nb;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         start16, bin16, busy16, done16, bout16, ovf16;
  logic [N-1:0] a16, b16, diff16;
  logic         start1, bin1, busy1, done1, bout1, ovf1;
  logic [0:0]   a1, b1, diff1;

  int nvec = 0;
  int nerr = 0;

  // expected {diff, bout, ovf}
  logic [N+1:0] q16[$];
  logic [2:0]   q1[$];

  serial_subtractor_nb #(.n(N)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  serial_subtractor_nb #(.n(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 16-bit instance: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done16: got done=1 expected no result pending");
      end else begin
        logic [N+1:0] e;
        e = q16.pop_front();
        check("diff16", 32'(diff16), 32'(e[N+1:2]));
        check("bout16", 32'(bout16), 32'(e[1]));
        check("ovf16",  32'(ovf16),  32'(e[0]));
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done1: got done=1 expected no result pending");
      end else begin
        logic [2:0] e;
        e = q1.pop_front();
        check("diff1", 32'(diff1), 32'(e[2]));
        check("bout1", 32'(bout1), 32'(e[1]));
        check("ovf1",  32'(ovf1),  32'(e[0]));
      end
    end
  end

  // Independent reference: widened subtraction plus sign-rule overflow.
  function automatic logic [N+1:0] model16(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] t;
    logic       v;
    t = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    v = (x[N-1] != y[N-1]) && (t[N-1] != x[N-1]);
    return {t[N-1:0], t[N], v};
  endfunction

  // Launch one 16-bit op; wait for done while checking latency and pulse shape.
  task automatic op16(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                      input logic [N+1:0] exp);
    int lat, busyc;
    @(negedge clk);
    a16 = x; b16 = y; bin16 = c; start16 = 1'b1;
    q16.push_back(exp);
    @(negedge clk);
    start16 = 1'b0;
    lat = 0; busyc = 0;
    while (!done16 && lat < 40) begin
      if (busy16) busyc++;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(N));
    check("busy_cycles", 32'(busyc), 32'(N));
    @(negedge clk);
    check("done_width", 32'(done16), 32'd0);
  endtask

  task automatic op1(input logic x, input logic y, input logic c);
    logic [1:0] t;
    logic       v;
    int         k;
    t = {1'b0, x} - {1'b0, y} - {1'b0, c};
    v = (x != y) && (t[0] != x);
    @(negedge clk);
    a1 = x; b1 = y; bin1 = c; start1 = 1'b1;
    q1.push_back({t[0], t[1], v});
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("latency1", 32'(k), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int k, ndone;
    logic [N-1:0] held;
    rst_n = 1'b0; start16 = 0; start1 = 0;
    a16 = '0; b16 = '0; bin16 = 0; a1 = '0; b1 = '0; bin1 = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_diff", 32'(diff16), 32'd0);
    check("rst_bout", 32'(bout16), 32'd0);
    check("rst_ovf",  32'(ovf16),  32'd0);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results {diff, bout, ovf}.
    op16(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0});
    op16(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});
    op16(16'h0005, 16'h0005, 1'b1, {16'hFFFF, 1'b1, 1'b0});
    op16(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1});
    op16(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1});

    // Starts during SHIFT and DONE must be ignored.
    @(negedge clk);
    a16 = 16'h00F0; b16 = 16'h000F; bin16 = 1'b0; start16 = 1'b1;
    q16.push_back({16'h00E1, 1'b0, 1'b0});
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(negedge clk);
    a16 = 16'd9; b16 = 16'd3; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ign_done_seen", 32'(done16), 32'd1);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    held = diff16;
    check("ign_hold_a", 32'(held), 32'h00E1);
    ndone = 0;
    repeat (N + 6) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("ign_no_second_done", 32'(ndone), 32'd0);
    check("ign_hold_b", 32'(diff16), 32'h00E1);
    check("ign_idle", 32'(busy16), 32'd0);

    // Reset during SHIFT aborts the operation.
    @(negedge clk);
    a16 = 16'h4444; b16 = 16'h1111; bin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_diff", 32'(diff16), 32'd0);
    check("abort_bout", 32'(bout16), 32'd0);
    check("abort_ovf",  32'(ovf16),  32'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    rst_n = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    op16(16'h4444, 16'h1111, 1'b0, {16'h3333, 1'b0, 1'b0});

    // n=1 exhaustive sweep.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    // Random 16-bit vectors.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] x, y;
      logic c;
      x = N'($urandom);
      y = N'($urandom);
      c = 1'($urandom_range(0, 1));
      op16(x, y, c, model16(x, y, c));
    end

    repeat (4) @(negedge clk);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q1_drained",  32'(q1.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
